// File: rtl/dot_product_mac.sv
// Pipelined signed dot-product / multiply-accumulate unit: multiply, lane-sum, accumulate.
// Define DOT_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module dot_product_mac #(
   parameter int LANES  = 9,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_a,
   input  logic [LANES*DATA_W-1:0] in_b,
   input  logic                    in_first,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        out_data,
   output logic                    out_ovf
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + $clog2(LANES);

   // Handshake: a beat moves when in_valid & in_ready; a result leaves when
   // out_valid & out_ready. The whole pipeline freezes while a result is held.
   logic stall;
   logic accept;

   logic [LANES*PROD_W-1:0] prod_q, prod_d;
   logic                    s1_valid_q, s1_valid_d;
   logic                    s1_first_q, s1_first_d;
   logic                    s1_last_q, s1_last_d;

   logic signed [SUM_W-1:0] s2_sum_q, s2_sum_d;
   logic                    s2_valid_q, s2_valid_d;
   logic                    s2_first_q, s2_first_d;
   logic                    s2_last_q, s2_last_d;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    acc_ovf_q, acc_ovf_d;
   logic                    win_open_q, win_open_d;
   logic [ACC_W-1:0]        out_data_q, out_data_d;
   logic                    out_ovf_q, out_ovf_d;
   logic                    out_valid_q, out_valid_d;

   logic signed [PROD_W-1:0] lane_a, lane_b, lane_p;
   logic signed [ACC_W-1:0]  sum_ext, base;
   logic        [ACC_W:0]    exact;
   logic        [ACC_W-1:0]  acc_new;
   logic                     restart, beat_ovf, ovf_new;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

   // S1: full-precision products
   always_comb begin
      prod_d     = prod_q;
      s1_valid_d = s1_valid_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      lane_a     = '0;
      lane_b     = '0;
      if (!stall) begin
         s1_valid_d = accept;
         s1_first_d = in_first;
         s1_last_d  = in_last;
         for (int k = 0; k < LANES; k++) begin
            lane_a = PROD_W'($signed(in_a[k*DATA_W +: DATA_W]));
            lane_b = PROD_W'($signed(in_b[k*DATA_W +: DATA_W]));
            prod_d[k*PROD_W +: PROD_W] = lane_a * lane_b;
         end
      end
   end

   // S2: lane sum, wide enough that it never overflows
   always_comb begin
      s2_sum_d   = s2_sum_q;
      s2_valid_d = s2_valid_q;
      s2_first_d = s2_first_q;
      s2_last_d  = s2_last_q;
      lane_p     = '0;
      if (!stall) begin
         s2_valid_d = s1_valid_q;
         s2_first_d = s1_first_q;
         s2_last_d  = s1_last_q;
         s2_sum_d   = '0;
         for (int k = 0; k < LANES; k++) begin
            lane_p   = prod_q[k*PROD_W +: PROD_W];
            s2_sum_d = s2_sum_d + SUM_W'(lane_p);
         end
      end
   end

   // S3: accumulate; the ACC_W+1-bit exact sum exposes overflow in its top two bits
   always_comb begin
      sum_ext  = ACC_W'(s2_sum_q);
      restart  = s2_first_q | ~win_open_q;
      base     = restart ? '0 : acc_q;
      exact    = {base[ACC_W-1], base} + {sum_ext[ACC_W-1], sum_ext};
      beat_ovf = exact[ACC_W] ^ exact[ACC_W-1];
`ifdef DOT_SAT_EN
      if (beat_ovf)
         acc_new = exact[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         acc_new = exact[ACC_W-1:0];
`else
      acc_new = exact[ACC_W-1:0];
`endif
      ovf_new = (restart ? 1'b0 : acc_ovf_q) | beat_ovf;

      acc_d       = acc_q;
      acc_ovf_d   = acc_ovf_q;
      win_open_d  = win_open_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = stall;
      if (s2_valid_q && !stall) begin
         acc_d = acc_new;
         if (s2_last_q) begin
            out_data_d  = acc_new;
            out_ovf_d   = ovf_new;
            out_valid_d = 1'b1;
            win_open_d  = 1'b0;
            acc_ovf_d   = 1'b0;
         end else begin
            acc_ovf_d  = ovf_new;
            win_open_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s2_sum_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_first_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         win_open_q  <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         s1_valid_q  <= s1_valid_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s2_sum_q    <= s2_sum_d;
         s2_valid_q  <= s2_valid_d;
         s2_first_q  <= s2_first_d;
         s2_last_q   <= s2_last_d;
         acc_q       <= acc_d;
         acc_ovf_q   <= acc_ovf_d;
         win_open_q  <= win_open_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: doc/dot_product_mac.md
Name: dot_product_mac

Overview:
- Parametrised, pipelined signed dot-product / multiply-accumulate unit.
- Each accepted beat carries LANES pairs of DATA_W-bit signed operands. The block multiplies each pair, sums the lanes, and accumulates the sum across a multi-beat window framed by in_first/in_last.
- Successor to the fixed 9-lane 8x8 multiplier; sits between the PE operand fetch and the output/activation stage.
- valid/ready handshakes on both sides.

Parameters:
- LANES, 9, number of multiplier lanes per beat (>=1).
- DATA_W, 8, signed operand width per lane.
- ACC_W, 32, signed accumulator/result width; must be >= 2*DATA_W + clog2(LANES).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  LANES*DATA_W  multiplicands; lane k at [k*DATA_W +: DATA_W], signed.
- in_b  in  LANES*DATA_W  multipliers, same packing.
- in_first  in  1  beat starts a new accumulation (accumulator cleared before adding).
- in_last  in  1  beat ends accumulation; result emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed accumulated result.
- out_ovf  out  1  accumulation overflowed ACC_W (sticky within window).

Behaviour:
- Reset (sync, active-high): s1_valid, s2_valid, out_valid, out_ovf = 0; out_data = 0; accumulator = 0; in_ready = 1 in the cycle after reset deasserts.
- Stall condition: stall = out_valid & ~out_ready.
- in_ready = ~stall. A beat is accepted when in_valid & in_ready.
- While stall is high, every stage register holds its value; out_data and out_ovf stay stable.
- Pipeline stages:
  - S1: register LANES full-precision signed products (2*DATA_W bits each) plus first/last tags.
  - S2: register the signed lane sum, width 2*DATA_W + clog2(LANES).
  - S3: accumulator update. If tag first, or if no window is open, acc = sign-extended sum; otherwise acc = acc + sum.
- Latency: last beat accepted in cycle t -> out_valid = 1 in cycle t+3 when there is no stall. Throughput is one beat per cycle.
- Result emission: when an S2 beat tagged last updates the accumulator, out_data = new acc value, out_valid = 1, and the window closes. The next beat starts from 0 even if in_first is low.
- out_valid clears on out_ready unless a new last result is written in the same cycle (back-to-back results allowed).
- A single beat with in_first = in_last = 1 yields that beat's dot product.
- Overflow:
  - Detected when the exact ACC_W+1-bit sum does not fit in ACC_W signed bits.
  - Default behaviour: wrap (two's complement) and set the sticky flag.
  - The flag is cleared by a first-tagged beat or when the window closes. out_ovf reflects the flag for the emitted window.
- Reset mid-window: all in-flight beats and the partial accumulation are discarded, and no result is emitted.
- A beat without in_first while a window is open continues that window. A beat with in_first while a window is open restarts it; the prior partial value is discarded and no result is emitted.

Optional Feature:
- Macro: DOT_SAT_EN.
- When defined, the accumulator saturates on overflow to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the sign of the true result; out_ovf behaves identically.
- When undefined, the accumulator wraps modulo 2^ACC_W.

Test Plan:
- Single beat, all lanes a=3, b=5, first=last=1 -> out_valid exactly 3 cycles after acceptance, out_data=135, out_ovf=0.
- Single beat, all lanes a=-128, b=-128 -> out_data=147456. Next beat all lanes a=-128, b=127, first=last=1 -> out_data=-146304.
- 4-beat window (first on beat0, last on beat3), each beat all lanes a=-128, b=127 -> one result, out_data=-585216. No out_valid during beats 0-2.
- Backpressure: out_ready held 0 for 5 cycles while a result is pending -> out_valid stays 1, out_data constant, in_ready=0. Releasing out_ready gives one handshake and in_ready=1 the same cycle.
- ACC_W=20, 4-beat window of all lanes -128*-128 (147456 each) -> without DOT_SAT_EN out_data=-458752, out_ovf=1. With DOT_SAT_EN out_data=524287, out_ovf=1.
- Reset asserted 1 cycle after two beats of a 4-beat window -> out_valid stays 0. The following single beat (a=1, b=1 all lanes, first=last) -> out_data=9, out_ovf=0.
